ws2812_chain_tx: RTL and testbench
==================================

Name: ws2812_chain_tx

Overview:
- Parametrised return-to-zero (WS2812-class) serial LED chain transmitter.
- Sends a frame of 1..MAX_LEDS pixels per start request, taken from a valid/ready pixel stream through a one-pixel prefetch buffer, then drives the latch/reset gap.
- Supports 24- or 32-bit pixels, programmable bit timing, optional RGB→GRB byte reordering, and underrun detection.
- Sits between the pixel/frame source logic and the LED data pin.

Parameters:
- BPP, 24, bits per pixel; legal values 24 or 32.
- MAX_LEDS, 256, maximum pixels per frame; CW = clog2(MAX_LEDS+1).
- TBIT_CYC, 62, clocks per bit period (1.24 us at 50 MHz).
- T0H_CYC, 20, high clocks for a '0' bit (400 ns).
- T1H_CYC, 40, high clocks for a '1' bit (800 ns).
- RESET_CYC, 4000, low clocks of the latch gap (80 us).

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  frame request pulse; sampled only in IDLE.
- num_leds  in  CW  pixels in this frame; sampled when start is accepted.
- order  in  1  0 = pixel sent as supplied; 1 = input {R,G,B[,W]} is sent as G,R,B[,W].
- pix_data  in  BPP  pixel word, MSB-first semantics.
- pix_valid  in  1  pixel word valid.
- pix_ready  out  1  block accepts pixel this cycle.
- rz_data  out  1  serial line to the LED chain.
- busy  out  1  high from start acceptance until frame_done.
- frame_done  out  1  one-cycle pulse at end of latch gap.
- underrun  out  1  one-cycle pulse when a frame is aborted for missing data.
- pix_sent  out  CW  pixels fully transmitted in the current or last frame.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; rz_data=0, busy=0, frame_done=0, underrun=0, pix_sent=0; buffer empty, so pix_ready=1 once rst deasserts.
- Buffer:
  - pix_ready = ~buf_full, registered-state based, valid in every state including IDLE (prefetch allowed).
  - Transfer occurs when pix_valid & pix_ready.
  - Reorder is applied on capture into the buffer.
- IDLE: rz_data=0. When start=1: latch num_leds, clear pix_sent, set busy=1 next cycle. If num_leds=0 go to LATCH; else go to LOAD. A start while busy=1 is ignored.
- LOAD: rz_data=0; wait indefinitely for buf_full (no timing constraint before the first bit). When buf_full: move buffer to shifter, clear buffer, bit_idx=BPP-1, cyc=0, go to SEND.
- SEND:
  - cyc counts 0..TBIT_CYC-1.
  - rz_data=1 while cyc < (shifter[MSB] ? T1H_CYC : T0H_CYC), else 0. rz_data is registered; the first high cycle appears one clock after LOAD exits.
  - On cyc=TBIT_CYC-1: shift left and decrement bit_idx.
  - On the last cycle of bit 0: pix_sent increments.
    - If pix_sent+1 = num_leds, go to LATCH.
    - Else if buf_full, reload shifter from buffer with no gap (next bit period starts the next cycle).
    - Else pulse underrun, go to LATCH (frame aborted, line stays low).
- LATCH: rz_data=0 for RESET_CYC cycles. Then frame_done=1 for one cycle, busy=0, go to IDLE. pix_sent holds until the next start.
- Bit timing is exact: every bit is TBIT_CYC clocks, including across pixel boundaries. Frame length for N pixels is N·BPP·TBIT_CYC + RESET_CYC clocks from first high edge to frame_done.
- Reset asserted mid-frame: immediate return to reset values; rz_data drops to 0 asynchronously; buffered pixel discarded.
- Parameter legality (simulation assertion): T0H_CYC < T1H_CYC < TBIT_CYC; BPP ∈ {24,32}.

Test Plan:
- Single pixel, order=0, default params, pix_data=24'hAA0000 preloaded, start with num_leds=1 → 24 bit periods of 62 clk. High widths are 40,20,40,20,40,20,40,20, then sixteen of 20. Then 4000 low clocks, then frame_done pulse; pix_sent=1.
- order=1, pix_data=24'h112233 → transmitted sequence is 24'h221133 MSB-first (decode high widths).
- num_leds=4, source keeps pix_valid=1 → exactly 4·24·62 clocks of data with no extra low time between pixels. pix_ready deasserts while the buffer is full; busy spans the whole frame.
- num_leds=3, source supplies only 2 pixels → underrun pulses on the last cycle of pixel 2. Line is low for RESET_CYC, then frame_done; pix_sent=2.
- num_leds=0 → no high pulses; frame_done exactly RESET_CYC+1 cycles after start; a start asserted mid-frame is ignored.
- rst=1 pulsed during bit 10 of pixel 1 → rz_data=0, busy=0, pix_ready=1 immediately. A new start afterwards transmits a full correct frame.

Source files
------------

// File: rtl/ws2812_chain_tx.sv
// ws2812_chain_tx: return-to-zero serial transmitter for WS2812-class LED chains.
// Pulls pixels from a valid/ready stream through a one-pixel prefetch buffer,
// shifts each pixel out MSB-first with exact bit timing, then holds the line
// low for the latch gap before signalling frame_done.
module ws2812_chain_tx #(
    parameter int BPP       = 24,
    parameter int MAX_LEDS  = 256,
    parameter int TBIT_CYC  = 62,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int RESET_CYC = 4000,
    localparam int CW       = $clog2(MAX_LEDS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [CW-1:0]  num_leds,
    input  logic           order,
    input  logic [BPP-1:0] pix_data,
    input  logic           pix_valid,
    output logic           pix_ready,
    output logic           rz_data,
    output logic           busy,
    output logic           frame_done,
    output logic           underrun,
    output logic [CW-1:0]  pix_sent
);

    localparam int CYW = $clog2(TBIT_CYC);
    localparam int BIW = $clog2(BPP);
    localparam int LCW = $clog2(RESET_CYC + 1);

    localparam bit PARAMS_OK = (T0H_CYC < T1H_CYC) && (T1H_CYC < TBIT_CYC) &&
                               ((BPP == 24) || (BPP == 32));

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_LATCH
    } state_t;

    state_t         state_q, state_d;
    logic [CYW-1:0] cyc_q, cyc_d;
    logic [BIW-1:0] bit_idx_q, bit_idx_d;
    logic [BPP-1:0] shift_q, shift_d;
    logic [BPP-1:0] buf_q, buf_d;
    logic           buf_full_q, buf_full_d;
    logic [CW-1:0]  nled_q, nled_d;
    logic [CW-1:0]  sent_q, sent_d;
    logic [LCW-1:0] lat_q, lat_d;
    logic           rz_q, rz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ur_q, ur_d;

    logic [BPP-1:0] pix_ord;
    logic           bit_end;
    logic           last_pix;

    // Optional R/G swap of the two top bytes; anything below them passes through.
    always_comb begin
        pix_ord = pix_data;
        if (order) begin
            pix_ord = {pix_data[BPP-9 -: 8], pix_data[BPP-1 -: 8], pix_data[BPP-17:0]};
        end
    end

    // Next-state, buffer and output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        nled_d     = nled_q;
        sent_d     = sent_q;
        lat_d      = lat_q;
        rz_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ur_d       = 1'b0;

        bit_end  = (cyc_q == CYW'(TBIT_CYC - 1));
        last_pix = ((sent_q + CW'(1)) == nled_q);

        // Prefetch runs in every state; a capture and a drain never coincide
        // because capture needs an empty buffer and drain needs a full one.
        if (pix_valid && !buf_full_q) begin
            buf_d      = pix_ord;
            buf_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nled_d = num_leds;
                    sent_d = '0;
                    busy_d = 1'b1;
                    if (num_leds == '0) begin
                        // No data: the gap is measured straight from start.
                        state_d = S_LATCH;
                        lat_d   = LCW'(RESET_CYC - 1);
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (buf_full_q) begin
                    shift_d    = buf_q;
                    buf_full_d = 1'b0;
                    bit_idx_d  = BIW'(BPP - 1);
                    cyc_d      = '0;
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                rz_d  = shift_q[BPP-1] ? (cyc_q < CYW'(T1H_CYC)) : (cyc_q < CYW'(T0H_CYC));
                cyc_d = cyc_q + CYW'(1);
                if (bit_end) begin
                    cyc_d     = '0;
                    shift_d   = shift_q << 1;
                    bit_idx_d = bit_idx_q - BIW'(1);
                    if (bit_idx_q == '0) begin
                        sent_d = sent_q + CW'(1);
                        // The line lags the state by one register, so a gap
                        // entered from SEND waits one extra cycle to give a
                        // full RESET_CYC of low time after the last bit.
                        if (last_pix) begin
                            state_d = S_LATCH;
                            lat_d   = LCW'(RESET_CYC);
                        end else if (buf_full_q) begin
                            shift_d    = buf_q;
                            buf_full_d = 1'b0;
                            bit_idx_d  = BIW'(BPP - 1);
                        end else begin
                            ur_d    = 1'b1;
                            state_d = S_LATCH;
                            lat_d   = LCW'(RESET_CYC);
                        end
                    end
                end
            end

            S_LATCH: begin
                if (lat_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    lat_d = lat_q - LCW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drops the line and discards any buffered pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            nled_q     <= '0;
            sent_q     <= '0;
            lat_q      <= '0;
            rz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ur_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            nled_q     <= nled_d;
            sent_q     <= sent_d;
            lat_q      <= lat_d;
            rz_q       <= rz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ur_q       <= ur_d;
        end
    end

    assign pix_ready  = ~buf_full_q;
    assign rz_data    = rz_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign underrun   = ur_q;
    assign pix_sent   = sent_q;

    // Timing parameters must leave a distinguishable 0/1 and a low tail.
    a_params_ok : assert property (@(posedge clk) PARAMS_OK)
        else $error("ws2812_chain_tx: illegal BPP or bit timing parameters");

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// tb_ws2812_chain_tx: frame-level checks of ws2812_chain_tx against a
// waveform model built from the bit-timing rules.
`timescale 1ns/1ps
module tb_ws2812_chain_tx;

    localparam int BPP      = 24;
    localparam int MAX_LEDS = 256;
    localparam int TBIT     = 62;
    localparam int T0H      = 20;
    localparam int T1H      = 40;
    localparam int RST_CYC  = 4000;
    localparam int CW       = $clog2(MAX_LEDS + 1);
    localparam int PIX_CYC  = BPP * TBIT;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [CW-1:0]  num_leds = '0;
    logic           order = 1'b0;
    logic [BPP-1:0] pix_data;
    logic           pix_valid;
    logic           pix_ready;
    logic           rz_data;
    logic           busy;
    logic           frame_done;
    logic           underrun;
    logic [CW-1:0]  pix_sent;

    int n_chk  = 0;
    int n_fail = 0;

    // Pixel source: main process appends words, source process consumes them.
    logic [BPP-1:0] src_mem [64];
    int src_wr    = 0;
    int src_rd    = 0;
    int flush_gen = 0;

    typedef struct packed {
        logic                 ord;
        logic [7:0]           n;
        logic [7:0]           nsup;
        logic [15:0]          inj;
        logic [3:0][BPP-1:0]  w;
        logic [3:0][BPP-1:0]  exp_w;
        logic [7:0]           exp_sent;
        logic                 exp_ur;
    } vec_t;

    ws2812_chain_tx #(
        .BPP(BPP), .MAX_LEDS(MAX_LEDS), .TBIT_CYC(TBIT),
        .T0H_CYC(T0H), .T1H_CYC(T1H), .RESET_CYC(RST_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_leds(num_leds), .order(order),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .rz_data(rz_data), .busy(busy), .frame_done(frame_done),
        .underrun(underrun), .pix_sent(pix_sent)
    );

    always #10 clk = ~clk;

    initial begin : watchdog
        #1900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : source
        int seen;
        bit take;
        seen      = 0;
        pix_valid = 1'b0;
        pix_data  = '0;
        forever begin
            @(negedge clk);
            take = pix_valid && pix_ready;
            @(posedge clk);
            if (flush_gen != seen) begin
                seen   = flush_gen;
                src_rd = src_wr;
            end else if (take) begin
                src_rd++;
            end
            #1;
            pix_valid = (src_rd != src_wr);
            pix_data  = pix_valid ? src_mem[src_rd % 64] : '0;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pix(input logic [BPP-1:0] w);
        src_mem[src_wr % 64] = w;
        src_wr++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        flush_gen++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference reordering: treat the word as a byte list, swap first two.
    function automatic logic [BPP-1:0] ref_order(input logic ord, input logic [BPP-1:0] w);
        logic [7:0] by [BPP/8];
        logic [7:0] t;
        logic [BPP-1:0] r;
        for (int i = 0; i < BPP/8; i++) by[i] = w[BPP-1-8*i -: 8];
        if (ord) begin
            t = by[0]; by[0] = by[1]; by[1] = t;
        end
        r = '0;
        for (int i = 0; i < BPP/8; i++) r = {r[BPP-9:0], by[i]};
        return r;
    endfunction

    function automatic vec_t mk(input logic ord, input int n, input int nsup, input int inj,
                                input logic [3:0][BPP-1:0] w, input logic [3:0][BPP-1:0] e,
                                input int sent, input logic ur);
        vec_t v;
        v.ord = ord; v.n = 8'(n); v.nsup = 8'(nsup); v.inj = 16'(inj);
        v.w = w; v.exp_w = e; v.exp_sent = 8'(sent); v.exp_ur = ur;
        return v;
    endfunction

    // Run one frame and compare the recorded line against the model waveform.
    task automatic run_vec(input vec_t v);
        bit line[$];
        bit bq[$];
        bit uq[$];
        int fd_idx, first, nbt, mism, ur_cnt, ur_idx, bad_busy, rdy_low, hw, p, b, c;
        bit e;
        logic [BPP-1:0] dw;

        order = v.ord;
        for (int i = 0; i < v.nsup; i++) push_pix(v.w[i]);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; num_leds = CW'(v.n);
        @(posedge clk);
        #1 start = 1'b0;

        fd_idx = -1; rdy_low = 0;
        for (int i = 0; i < 20000 && fd_idx < 0; i++) begin
            @(negedge clk);
            line.push_back(rz_data); bq.push_back(busy); uq.push_back(underrun);
            if (!pix_ready) rdy_low++;
            if (frame_done) fd_idx = i;
            if (v.inj != 0 && i == int'(v.inj)) begin
                start = 1'b1; num_leds = CW'(1);
            end else begin
                start = 1'b0; num_leds = CW'(v.n);
            end
        end
        start = 1'b0;

        chk("frame_done seen", fd_idx >= 0, 1);
        if (fd_idx < 0) begin
            do_reset();
            return;
        end

        first = -1;
        foreach (line[i]) if (line[i] && first < 0) first = i;
        nbt = int'(v.exp_sent) * PIX_CYC;

        if (v.exp_sent == 0) begin
            chk("no high pulses", first, -1);
            chk("frame_done offset from start", fd_idx, RST_CYC);
        end else begin
            chk("line started", first >= 0, 1);
            if (first >= 0) begin
                mism = 0;
                for (int i = 0; i < nbt + RST_CYC; i++) begin
                    e = 1'b0;
                    if (i < nbt) begin
                        p = i / PIX_CYC; b = (i / TBIT) % BPP; c = i % TBIT;
                        e = (c < (v.exp_w[p][BPP-1-b] ? T1H : T0H));
                    end
                    if (first + i >= line.size() || line[first+i] != e) mism++;
                end
                chk("waveform mismatched cycles", mism, 0);
                chk("frame_done offset from first high", fd_idx - first, nbt + RST_CYC);
                for (int q = 0; q < int'(v.exp_sent); q++) begin
                    dw = '0;
                    for (int bb = 0; bb < BPP; bb++) begin
                        hw = 0;
                        for (int cc = 0; cc < TBIT; cc++) hw += int'(line[first + q*PIX_CYC + bb*TBIT + cc]);
                        dw = {dw[BPP-2:0], (hw > (T0H + T1H) / 2)};
                    end
                    chk($sformatf("decoded pixel %0d", q), dw, v.exp_w[q]);
                end
            end
        end

        ur_cnt = 0; ur_idx = -1;
        foreach (uq[i]) if (uq[i]) begin
            ur_cnt++;
            if (ur_idx < 0) ur_idx = i;
        end
        chk("underrun pulse count", ur_cnt, v.exp_ur);
        if (v.exp_ur && first >= 0) chk("underrun position", ur_idx - first, nbt - 1);

        bad_busy = 0;
        for (int i = 0; i <= fd_idx; i++) if (bq[i] != (i < fd_idx)) bad_busy++;
        chk("busy span", bad_busy, 0);
        chk("pix_sent at frame_done", pix_sent, v.exp_sent);
        if (v.nsup >= 2) chk("pix_ready low while buffer full", rdy_low > 0, 1);

        @(negedge clk);
        chk("frame_done single cycle", frame_done, 0);
        chk("pix_sent holds", pix_sent, v.exp_sent);
        chk("idle after frame", busy, 0);
        chk("source drained", src_wr - src_rd, 0);
    endtask

    initial begin : main
        vec_t vecs [8];
        int n, ns, got;
        logic o;
        logic [3:0][BPP-1:0] w;

        vecs[0] = mk(0, 1, 1, 0, {72'h0, 24'hAA0000}, {72'h0, 24'hAA0000}, 1, 0);
        vecs[1] = mk(1, 1, 1, 0, {72'h0, 24'h112233}, {72'h0, 24'h221133}, 1, 0);
        vecs[2] = mk(0, 4, 4, 0, {24'hC3A55A, 24'h00FF00, 24'h7FFFFE, 24'h800001},
                                 {24'hC3A55A, 24'h00FF00, 24'h7FFFFE, 24'h800001}, 4, 0);
        vecs[3] = mk(1, 3, 2, 0, {48'h0, 24'hF0E1D2, 24'h0A0B0C},
                                 {48'h0, 24'hE1F0D2, 24'h0B0A0C}, 2, 1);
        vecs[4] = mk(0, 0, 0, 100, '0, '0, 0, 0);
        for (int r = 5; r < 8; r++) begin
            o  = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(1, 3));
            ns = int'($urandom_range(1, n));
            for (int i = 0; i < 4; i++) w[i] = BPP'($urandom);
            vecs[r] = mk(o, n, ns, 0, w, '0, ns, ns < n);
            for (int i = 0; i < ns; i++) vecs[r].exp_w[i] = ref_order(o, w[i]);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset rz_data", rz_data, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset underrun", underrun, 0);
        chk("reset pix_sent", pix_sent, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("pix_ready after reset", pix_ready, 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset in the middle of bit 10 of pixel 1, with pixel 2 buffered.
        order = 1'b0;
        push_pix(24'h5A5A5A);
        push_pix(24'hC0FFEE);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; num_leds = CW'(2);
        @(posedge clk);
        #1 start = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (rz_data) got = 1;
        end
        chk("mid-frame reset: line started", got, 1);
        repeat (10 * TBIT + 5) @(negedge clk);
        chk("line high inside bit 10", rz_data, 1);
        #2 rst = 1'b1;
        flush_gen++;
        #1;
        chk("reset mid-frame rz_data", rz_data, 0);
        chk("reset mid-frame busy", busy, 0);
        chk("reset mid-frame pix_ready", pix_ready, 1);
        chk("reset mid-frame pix_sent", pix_sent, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(0, 1, 1, 0, {72'h0, 24'h3C00C3}, {72'h0, 24'h3C00C3}, 1, 0));

        for (int i = 5; i < 8; i++) run_vec(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
